// File: rtl/sweep_ctrl.sv
// sweep_ctrl: frequency-sweep sequencer for the DDS phase accumulator.
// Shadows start/end/step/dwell on a start request, then walks fre_k from start
// toward end in fixed steps, holding each point for dwell clocks. The last step
// is clamped so fre_k never passes end, in either sweep direction.
module sweep_ctrl #(
    parameter logic [31:0] FRE_DEFAULT = 32'd34360,
    parameter int          LOOP        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] fre_start,
    input  logic [31:0] fre_end,
    input  logic [31:0] fre_step,
    input  logic [31:0] dwell,
    output logic [31:0] fre_k,
    output logic        busy,
    output logic        step_stb,
    output logic        done
);
    // Handshake: start and stop are single-cycle request pulses sampled on the
    // rising clk edge with no acknowledge; step_stb and done are single-cycle
    // registered strobes with no back-pressure. In IDLE a start accompanied by
    // stop is dropped; in RUN start is ignored and stop aborts the sweep.

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic        load_pend;   // start accepted, first point goes out next edge
    logic [31:0] sh_start;
    logic [31:0] sh_end;
    logic [31:0] sh_step;
    logic [31:0] sh_dwell;    // already forced to at least 1
    logic        dir_down;
    logic [31:0] dwell_cnt;

    logic [32:0] sum_up;
    logic [32:0] diff_dn;
    logic [31:0] next_k;
    logic        at_end;
    logic        dwell_hit;

    // Next sweep point: 33-bit add/subtract so carry or borrow clamps to end.
    always_comb begin
        sum_up    = {1'b0, fre_k} + {1'b0, sh_step};
        diff_dn   = {1'b0, fre_k} - {1'b0, sh_step};
        next_k    = sh_end;
        if (dir_down) begin
            if (!diff_dn[32] && (diff_dn[31:0] > sh_end)) next_k = diff_dn[31:0];
        end else begin
            if (!sum_up[32] && (sum_up[31:0] < sh_end)) next_k = sum_up[31:0];
        end
        // A zero step can never move, so it behaves as a one-point sweep.
        at_end    = (fre_k == sh_end) || (sh_step == 32'd0);
        dwell_hit = (dwell_cnt == sh_dwell);
    end

    // Sweep FSM with shadow registers, dwell counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            load_pend <= 1'b0;
            sh_start  <= 32'd0;
            sh_end    <= 32'd0;
            sh_step   <= 32'd0;
            sh_dwell  <= 32'd1;
            dir_down  <= 1'b0;
            dwell_cnt <= 32'd0;
            fre_k     <= FRE_DEFAULT;
            busy      <= 1'b0;
            step_stb  <= 1'b0;
            done      <= 1'b0;
        end else begin
            step_stb <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_pend) begin
                        load_pend <= 1'b0;
                        fre_k     <= sh_start;
                        busy      <= 1'b1;
                        step_stb  <= 1'b1;
                        dwell_cnt <= 32'd1;
                        state     <= RUN;
                    end else if (start && !stop) begin
                        load_pend <= 1'b1;
                        sh_start  <= fre_start;
                        sh_end    <= fre_end;
                        sh_step   <= fre_step;
                        sh_dwell  <= (dwell == 32'd0) ? 32'd1 : dwell;
                        dir_down  <= (fre_end < fre_start);
                    end
                end
                RUN: begin
                    if (stop) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        dwell_cnt <= 32'd0;
                    end else if (dwell_hit) begin
                        if (!at_end) begin
                            fre_k     <= next_k;
                            step_stb  <= 1'b1;
                            dwell_cnt <= 32'd1;
                        end else if (LOOP != 0) begin
                            fre_k     <= sh_start;
                            step_stb  <= 1'b1;
                            dwell_cnt <= 32'd1;
                        end else begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            dwell_cnt <= 32'd0;
                            state     <= IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: scoreboard bench for sweep_ctrl (one-shot and looping builds).
// The driver computes the point list from the sweep rules with plain arithmetic,
// turns it into timed events and queues them; monitors pop on every strobe.
module tb_sweep_ctrl;
    localparam logic [31:0] FRE_DEF = 32'd34360;
    localparam int          EW      = 66;      // {kind[1:0], fre_k[31:0], edge[31:0]}
    localparam logic [1:0]  K_STEP  = 2'b01;
    localparam logic [1:0]  K_DONE  = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, start_l, stop_l;
    logic [31:0] fre_start, fre_end, fre_step, dwell;
    logic [31:0] fre_k, fre_k_l;
    logic        busy, step_stb, done, busy_l, step_stb_l, done_l;

    int unsigned   cyc = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_l[$];
    logic [EW-1:0] ev_m, ev_l;
    logic [31:0]   pts[$];
    int            n_tests = 0;
    int            n_fail  = 0;

    sweep_ctrl #(.FRE_DEFAULT(FRE_DEF), .LOOP(0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .fre_start(fre_start), .fre_end(fre_end), .fre_step(fre_step), .dwell(dwell),
        .fre_k(fre_k), .busy(busy), .step_stb(step_stb), .done(done)
    );

    sweep_ctrl #(.FRE_DEFAULT(FRE_DEF), .LOOP(1)) dut_loop (
        .clk(clk), .rst(rst), .start(start_l), .stop(stop_l),
        .fre_start(fre_start), .fre_end(fre_end), .fre_step(fre_step), .dwell(dwell),
        .fre_k(fre_k_l), .busy(busy_l), .step_stb(step_stb_l), .done(done_l)
    );

    // clock / edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference point list: start, then step toward end, clamped, end inclusive.
    function automatic void make_points(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st);
        logic [31:0] p;
        p = s;
        pts.delete();
        pts.push_back(p);
        while (p != e && st != 32'd0 && pts.size() < 200) begin
            if (e > s) p = (e - p <= st) ? e : p + st;
            else       p = (p - e <= st) ? e : p - st;
            pts.push_back(p);
        end
    endfunction

    // monitor for the one-shot build
    always @(posedge clk) begin
        #1;
        if (!rst && (step_stb || done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, done, step_stb}, 32'd0);
            end else begin
                ev_m = exp_q.pop_front();
                check("event_kind", {30'd0, done, step_stb}, {30'd0, ev_m[65:64]});
                check("event_edge", cyc, ev_m[31:0]);
                check("event_fre_k", fre_k, ev_m[63:32]);
                check("event_busy", {31'd0, busy}, {31'd0, ev_m[65:64] == K_STEP});
            end
        end
    end

    // monitor for the looping build
    always @(posedge clk) begin
        #1;
        if (!rst && (step_stb_l || done_l)) begin
            if (exp_l.size() == 0) begin
                check("loop_unexpected_event", {30'd0, done_l, step_stb_l}, 32'd0);
            end else begin
                ev_l = exp_l.pop_front();
                check("loop_event_kind", {30'd0, done_l, step_stb_l}, {30'd0, ev_l[65:64]});
                check("loop_event_edge", cyc, ev_l[31:0]);
                check("loop_event_fre_k", fre_k_l, ev_l[63:32]);
                check("loop_event_busy", {31'd0, busy_l}, 32'd1);
            end
        end
    end

    // One-shot sweep. mode 0: run to done; 1: stop pulse; 2: reset pulse,
    // either landing cut_off+2 edges after the start edge.
    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                             input logic [31:0] dw, input int mode, input int cut_off);
        int unsigned n, dwe, done_t, cut_t, last_t, end_t, inj_t, t;
        logic [31:0] frozen;
        make_points(s, e, st);
        dwe = (dw == 32'd0) ? 1 : dw;
        @(negedge clk);
        n      = cyc + 1;
        done_t = n + 1 + pts.size() * dwe;
        cut_t  = (mode != 0) ? n + 2 + cut_off : 32'hFFFF_FFFF;
        frozen = pts[0];
        for (int i = 0; i < pts.size(); i++) begin
            t = n + 1 + i * dwe;
            if (t < cut_t) begin
                exp_q.push_back({K_STEP, pts[i], t});
                frozen = pts[i];
            end
        end
        if (done_t < cut_t) exp_q.push_back({K_DONE, pts[pts.size()-1], done_t});
        if (mode == 2) frozen = FRE_DEF;
        last_t = (done_t < cut_t) ? done_t : cut_t;
        end_t  = (mode != 0 && cut_t > last_t) ? cut_t : last_t;
        inj_t  = n + 2 + $urandom_range(0, last_t - n - 2);
        fre_start = s; fre_end = e; fre_step = st; dwell = dw;
        start = 1'b1; stop = 1'b0;
        while (cyc + 1 <= end_t + 2) begin
            @(negedge clk);
            start = (cyc + 1 == inj_t);
            stop  = (mode == 1) && (cyc + 1 == cut_t);
            rst   = (mode == 2) && (cyc + 1 == cut_t);
            fre_start = $urandom; fre_end = $urandom; fre_step = $urandom;
            dwell = $urandom_range(0, 5);
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0;
        check("drain", exp_q.size(), 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("fre_k_after", fre_k, frozen);
    endtask

    // Looping sweep, aborted by stop cut_off+2 edges after the start edge.
    task automatic run_loop(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                            input logic [31:0] dw, input int cut_off);
        int unsigned n, dwe, cut_t;
        logic [31:0] frozen;
        make_points(s, e, st);
        dwe = (dw == 32'd0) ? 1 : dw;
        @(negedge clk);
        n      = cyc + 1;
        cut_t  = n + 2 + cut_off;
        frozen = pts[0];
        for (int i = 0; n + 1 + i * dwe < cut_t; i++) begin
            frozen = pts[i % pts.size()];
            exp_l.push_back({K_STEP, frozen, n + 1 + i * dwe});
        end
        fre_start = s; fre_end = e; fre_step = st; dwell = dw;
        start_l = 1'b1; stop_l = 1'b0;
        while (cyc + 1 <= cut_t + 2) begin
            @(negedge clk);
            start_l = 1'b0;
            stop_l  = (cyc + 1 == cut_t);
            fre_start = $urandom; fre_end = $urandom;
        end
        stop_l = 1'b0;
        check("loop_drain", exp_l.size(), 32'd0);
        check("loop_busy_after", {31'd0, busy_l}, 32'd0);
        check("loop_fre_k_after", fre_k_l, frozen);
    endtask

    // main stimulus and final report
    initial begin
        logic [31:0] s, e, st, diff;
        int          mode;
        rst = 1'b1; start = 1'b0; stop = 1'b0; start_l = 1'b0; stop_l = 1'b0;
        fre_start = '0; fre_end = '0; fre_step = '0; dwell = '0;
        repeat (3) @(negedge clk);
        check("reset_fre_k", fre_k, FRE_DEF);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_strobes", {30'd0, done, step_stb}, 32'd0);
        check("reset_loop_fre_k", fre_k_l, FRE_DEF);
        rst = 1'b0;
        @(negedge clk);
        stop = 1'b1;                        // stop while idle is ignored
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_fre_k", fre_k, FRE_DEF);

        run_sweep(32'd100, 32'd400, 32'd100, 32'd3, 0, 0);
        run_sweep(32'd1000, 32'd700, 32'd200, 32'd2, 0, 0);
        run_sweep(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 32'd1, 0, 0);
        run_sweep(32'd50, 32'd50, 32'd0, 32'd0, 0, 0);
        run_sweep(32'd100, 32'd0, 32'd300, 32'd1, 0, 0);
        run_sweep(32'd100, 32'd400, 32'd100, 32'd3, 1, 3);   // stop while at 200
        run_sweep(32'd100, 32'd400, 32'd100, 32'd3, 2, 4);   // reset mid-run
        run_loop(32'd10, 32'd30, 32'd10, 32'd1, 10);

        for (int k = 0; k < 40; k++) begin
            s = $urandom;
            case ($urandom_range(0, 3))
                0: e = $urandom;
                1: e = s;
                2: begin s = 32'hFFFF_FF00 + $urandom_range(0, 64); e = 32'hFFFF_FFFF - $urandom_range(0, 3); end
                default: e = s + $urandom_range(0, 1000) - 32'd500;
            endcase
            diff = (e >= s) ? e - s : s - e;
            st = diff / $urandom_range(1, 8) + $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) st = $urandom;
            mode = ($urandom_range(0, 7) == 0) ? 2 : (($urandom_range(0, 3) == 0) ? 1 : 0);
            run_sweep(s, e, st, $urandom_range(0, 4), mode, $urandom_range(0, 40));
        end
        for (int k = 0; k < 6; k++) begin
            s  = $urandom_range(0, 1000);
            e  = $urandom_range(0, 1000);
            diff = (e >= s) ? e - s : s - e;
            st = diff / $urandom_range(1, 4) + $urandom_range(0, 1);
            run_loop(s, e, st, $urandom_range(0, 3), $urandom_range(0, 60));
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
